fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_fifo.sv | 36 +++
 rtl/fetch_unit.sv | 59 +++++
 tb/tb_fetch_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-path constants, buffer entry layout and address helper
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int INSTR_WIDTH = 32;
  localparam int FETCH_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with clear and occupancy count; head reads 0 when empty
module fetch_fifo #(
  parameter int W = 32,
  parameter int D = 4,
  localparam int AW = $clog2(D)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0] count
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != D[AW:0] || do_pop);
  assign dout = count == '0 ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + AW'(1);
      end
      if (do_pop) rd <= rd + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, credit-limited imem requests, instruction buffer with redirect flush
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic [31:0] npc_i,
  input  logic redirect_i,
  output logic imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic imem_req_ready,
  input  logic imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  input  logic id_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_q, head_pc4;
  logic [AW:0] inflight, buffered, discard_q;
  logic [AW+1:0] occ;
  logic req_fire, resp, keep;
  fetch_entry_t entry_in, entry_out;
  assign occ = {1'b0, inflight} + {1'b0, buffered};
  assign imem_req_valid = !rst && !redirect_i && occ < DEPTH[AW+1:0];
  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp = imem_resp_valid && inflight != '0;
  assign keep = resp && !redirect_i && discard_q == '0;
  assign entry_in = '{pc_plus4: head_pc4, instr: imem_resp_data};
  assign id_valid = buffered != '0;
  assign id_instr = entry_out.instr;
  assign id_pc_plus4 = entry_out.pc_plus4;
  // the address FIFO occupancy is the in-flight count; it is never flushed so stale responses still pop it
  fetch_fifo #(.W(32), .D(DEPTH)) addr_q (
    .clk, .rst, .clr(1'b0), .push(req_fire), .pop(resp),
    .din(pc_q + 32'd4), .dout(head_pc4), .count(inflight)
  );
  fetch_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) buf_q (
    .clk, .rst, .clr(redirect_i), .push(keep), .pop(id_valid && id_ready),
    .din(entry_in), .dout(entry_out), .count(buffered)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      discard_q <= '0;
    end else if (redirect_i) begin
      pc_q <= word_align(npc_i);
      discard_q <= inflight - {{AW{1'b0}}, resp};
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      if (resp && discard_q != '0) discard_q <= discard_q - {{AW{1'b0}}, 1'b1};
    end
  end
  always_ff @(posedge clk)
    if (!rst && imem_resp_valid) assert (inflight != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with in-order latency memory returning address as data
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 0, rst = 1;
  logic [31:0] npc_i = 0, imem_req_addr, imem_resp_data = 0, id_instr, id_pc_plus4;
  logic redirect_i = 0, imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0;
  logic id_valid, id_ready = 0;
  int total = 0, bad = 0, cyc = 0, lat = 1, acc = 0, dlv = 0, first_id = -1;
  logic [31:0] exp_pc, cap, prev_addr;
  logic cap_on = 0, saw_wrap = 0, hs_redir = 0;
  logic [31:0] expq[$], memq[$];
  int dueq[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .npc_i(npc_i), .redirect_i(redirect_i),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_ready(id_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; id_ready = 0; imem_req_ready = 0; redirect_i = 0; imem_resp_valid = 0; npc_i = 0;
    memq.delete(); dueq.delete(); expq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc_plus4", id_pc_plus4, 0);
    exp_pc = RESET_PC_DEF; cyc = 0; first_id = -1;
  endtask

  task automatic tick(input logic dr, input logic mr, input logic rd, input logic [31:0] tgt);
    logic [31:0] w;
    @(negedge clk);
    rst = 0; id_ready = dr; imem_req_ready = mr; redirect_i = rd; npc_i = tgt;
    imem_resp_valid = memq.size() > 0 && dueq[0] <= cyc;
    imem_resp_data = imem_resp_valid ? memq[0] : 32'hdead_beef;
    if (imem_resp_valid) begin
      void'(memq.pop_front());
      void'(dueq.pop_front());
    end
    #1;
    if (rd) check("req_during_redirect", imem_req_valid, 0);
    if (id_valid && first_id < 0) first_id = cyc;
    hs_redir = rd && id_valid && id_ready;
    if (id_valid && id_ready) begin
      dlv++;
      if (expq.size() == 0) check("unexpected_id_valid", id_valid, 0);
      else begin
        w = expq.pop_front();
        check("id_instr", id_instr, w);
        check("id_pc_plus4", id_pc_plus4, w + 32'd4);
      end
      if (cap_on) begin
        cap = id_pc_plus4;
        cap_on = 0;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_pc);
      if (imem_req_addr == 32'h0 && prev_addr == 32'hFFFF_FFFC) saw_wrap = 1;
      prev_addr = imem_req_addr;
      memq.push_back(imem_req_addr);
      dueq.push_back(cyc + lat);
      expq.push_back(exp_pc);
      exp_pc += 32'd4;
      acc++;
    end
    if (rd) begin
      expq.delete();
      exp_pc = {tgt[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    prev_addr = 0;
    do_reset();
    lat = 1;
    repeat (8) tick(1, 1, 0, 0);
    check("first_id_cycle", first_id, 2);
    dlv = 0;
    repeat (20) tick(1, 1, 0, 0);
    check("throughput", dlv, 20);

    do_reset();
    acc = 0;
    repeat (10) tick(0, 1, 0, 0);
    check("stall_reqs", acc, 4);
    check("stall_req_valid", imem_req_valid, 0);
    check("resume_addr", imem_req_addr, 32'h3010);
    repeat (10) tick(1, 1, 0, 0);

    lat = 3;
    repeat (6) tick(1, 1, 0, 0);
    check("inflight_before_redirect", memq.size() >= 2, 1);
    tick(1, 1, 1, 32'h0000_4002);
    cap_on = 1; cap = 0;
    repeat (12) tick(1, 1, 0, 0);
    check("redirect_target", cap, 32'h4004);

    dlv = 0;
    repeat (30) tick(1, (cyc % 2) == 0, 0, 0);
    check("toggle_progress", dlv >= 8, 1);

    lat = 1;
    repeat (6) tick(1, 1, 0, 0);
    tick(1, 1, 1, 32'hFFFF_FFF8);
    repeat (10) tick(1, 1, 0, 0);
    check("wrap_seen", saw_wrap, 1);

    tick(1, 1, 1, 32'h0000_5000);
    check("hs_in_redirect", hs_redir, 1);
    cap_on = 1; cap = 0;
    repeat (6) tick(1, 1, 0, 0);
    check("redirect_same_cycle", cap, 32'h5004);

    repeat (2) tick(1, 1, 0, 0);
    tick(1, 1, 1, 32'h0000_6000);
    tick(1, 1, 1, 32'h0000_7001);
    cap_on = 1; cap = 0;
    repeat (8) tick(1, 1, 0, 0);
    check("back_to_back_redirect", cap, 32'h7004);

    do_reset();
    first_id = -1;
    repeat (6) tick(1, 1, 0, 0);
    check("first_id_after_reset", first_id, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
